// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   IF-stage requester for a combinational instruction ROM. Owns the PC,
//   drives the ROM address and captures the returned word into the IF/ID
//   pipeline register. Handles stall, branch redirect (with misalignment
//   pulse), 32-bit PC wrap and halting on a run of all-zero words.
//
// Parameters
//   RESET_PC    PC value after reset
//   HALT_ZEROS  consecutive all-zero fetched words that trigger HALT (>=4)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   imem_addr     byte address to instruction ROM (the PC register)
//   imem_instr    word returned by the ROM for imem_addr, same cycle
//   stall         hold PC and IF/ID
//   redirect      branch/jump taken this cycle
//   redirect_pc   redirect target byte address
//   if_id_instr   registered instruction
//   if_id_pc4     registered pc+4 of that instruction
//   if_id_valid   if_id_instr is a real fetch (0 = bubble)
//   misalign_err  one-cycle pulse when a redirect target is not word aligned
//   halted        fetch unit is in HALT
//
// Optional build macro FETCH_PERF_EN adds perf_fetch (captured valid words)
// and perf_bubble (RUN cycles with stall or redirect), both wrapping 32-bit.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          HALT_ZEROS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  localparam int              ZW       = $clog2(HALT_ZEROS + 1);
  localparam logic [ZW-1:0]   HALT_CNT = ZW'(HALT_ZEROS);
  localparam logic [ZW-1:0]   ZERO_MAX = {ZW{1'b1}};

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state_r, state_next_s;
  logic [31:0]   pc_r, pc_next_s;
  logic [31:0]   instr_r, instr_next_s;
  logic [31:0]   pc4_r, pc4_next_s;
  logic          valid_r, valid_next_s;
  logic          misalign_r, misalign_next_s;
  logic          halted_r;
  logic [ZW-1:0] zero_cnt_r, zero_cnt_next_s;
  logic [ZW-1:0] zero_inc_s;
  logic [31:0]   pc_plus4_s;
  logic          fetch_inc_s;
  logic          bubble_inc_s;

  assign pc_plus4_s = pc_r + 32'd4;
  // Saturating increment keeps the counter from wrapping back to zero.
  assign zero_inc_s = (zero_cnt_r == ZERO_MAX) ? zero_cnt_r : zero_cnt_r + {{(ZW-1){1'b0}}, 1'b1};

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    instr_next_s    = instr_r;
    pc4_next_s      = pc4_r;
    valid_next_s    = valid_r;
    zero_cnt_next_s = zero_cnt_r;
    misalign_next_s = 1'b0;
    fetch_inc_s     = 1'b0;
    bubble_inc_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        // One idle cycle after reset: PC held, nothing captured.
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Redirect flushes IF/ID and beats a simultaneous stall.
          pc_next_s       = redirect_pc & 32'hFFFF_FFFC;
          instr_next_s    = 32'h0000_0000;
          valid_next_s    = 1'b0;
          zero_cnt_next_s = {ZW{1'b0}};
          misalign_next_s = |redirect_pc[1:0];
          bubble_inc_s    = 1'b1;
        end else if (stall) begin
          bubble_inc_s = 1'b1;
        end else begin
          pc_next_s    = pc_plus4_s;
          instr_next_s = imem_instr;
          pc4_next_s   = pc_plus4_s;
          valid_next_s = 1'b1;
          fetch_inc_s  = 1'b1;
          if (imem_instr == 32'h0000_0000) begin
            zero_cnt_next_s = zero_inc_s;
            // The word that completes the zero run is still captured.
            if (zero_inc_s == HALT_CNT) begin
              state_next_s = ST_HALT;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            zero_cnt_next_s = {ZW{1'b0}};
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          pc_next_s       = redirect_pc & 32'hFFFF_FFFC;
          instr_next_s    = 32'h0000_0000;
          valid_next_s    = 1'b0;
          zero_cnt_next_s = {ZW{1'b0}};
          misalign_next_s = |redirect_pc[1:0];
          state_next_s    = ST_RUN;
        end else begin
          // Stall is irrelevant here; the pipeline just sees bubbles.
          valid_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_BOOT;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      instr_r    <= 32'h0000_0000;
      pc4_r      <= 32'h0000_0000;
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
      halted_r   <= 1'b0;
      zero_cnt_r <= {ZW{1'b0}};
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      instr_r    <= instr_next_s;
      pc4_r      <= pc4_next_s;
      valid_r    <= valid_next_s;
      misalign_r <= misalign_next_s;
      halted_r   <= (state_next_s == ST_HALT);
      zero_cnt_r <= zero_cnt_next_s;
    end
  end

  assign imem_addr    = pc_r;
  assign if_id_instr  = instr_r;
  assign if_id_pc4    = pc4_r;
  assign if_id_valid  = valid_r;
  assign misalign_err = misalign_r;
  assign halted       = halted_r;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_bubble_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_r  <= 32'h0000_0000;
      perf_bubble_r <= 32'h0000_0000;
    end else begin
      if (fetch_inc_s) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (bubble_inc_s) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end
    end
  end

  assign perf_fetch  = perf_fetch_r;
  assign perf_bubble = perf_bubble_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = fetch_inc_s ^ bubble_inc_s;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a behavioural ROM table.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_ZEROS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .misalign_err (misalign_err),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch   (perf_fetch),
    .perf_bubble  (perf_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: two fixed words, NOPs at 0x40..0x48, zeros from 0x58 to 0xFC.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h518D_581B;
    if (a == 32'h0000_0004) return 32'h5128_401E;
    if (a == 32'h0000_0040 || a == 32'h0000_0044 || a == 32'h0000_0048) return 32'h0000_0000;
    if (a >= 32'h0000_0058 && a <= 32'h0000_00FC) return 32'h0000_0000;
    return a ^ 32'h1357_9BDF;
  endfunction

  always_comb imem_instr = rom(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #3;
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4",   if_id_pc4, 32'h0);
    check("rst_halt",  {31'b0, halted}, 32'h0);
    check("rst_mis",   {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    tick(); // BOOT edge
    check("boot_addr",  imem_addr, 32'h0);
    check("boot_valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    check("e2_instr", if_id_instr, 32'h518D_581B);
    check("e2_pc4",   if_id_pc4, 32'h4);
    check("e2_valid", {31'b0, if_id_valid}, 32'h1);
    tick();
    check("e3_instr", if_id_instr, 32'h5128_401E);
    check("e3_pc4",   if_id_pc4, 32'h8);
    check("e3_addr",  imem_addr, 32'h8);
    tick(); tick();
    check("pre_stall_addr", imem_addr, 32'h10);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  imem_addr, 32'h10);
      check("stall_pc4",   if_id_pc4, 32'h10);
      check("stall_instr", if_id_instr, rom(32'h0C));
    end
    stall = 1'b0;
    tick();
    check("resume_instr", if_id_instr, rom(32'h10));
    check("resume_pc4",   if_id_pc4, 32'h14);
    check("resume_addr",  imem_addr, 32'h14);

    redirect = 1'b1; redirect_pc = 32'h34; stall = 1'b1;
    tick();
    check("rd_addr",  imem_addr, 32'h34);
    check("rd_valid", {31'b0, if_id_valid}, 32'h0);
    check("rd_mis",   {31'b0, misalign_err}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check("rd2_valid", {31'b0, if_id_valid}, 32'h1);
    check("rd2_pc4",   if_id_pc4, 32'h38);
    check("rd2_instr", if_id_instr, rom(32'h34));

    redirect = 1'b1; redirect_pc = 32'h36;
    tick();
    check("mis_addr",  imem_addr, 32'h34);
    check("mis_pulse", {31'b0, misalign_err}, 32'h1);
    redirect = 1'b0;
    tick();
    check("mis_clear", {31'b0, misalign_err}, 32'h0);
    check("mis_pc4",   if_id_pc4, 32'h38);

    repeat (6) tick();
    check("nop_halt",  {31'b0, halted}, 32'h0);
    check("nop_instr", if_id_instr, rom(32'h4C));
    check("nop_addr",  imem_addr, 32'h50);
    repeat (2) tick();
    check("z_start", imem_addr, 32'h58);
    repeat (7) tick();
    check("z7_halt", {31'b0, halted}, 32'h0);
    check("z7_addr", imem_addr, 32'h74);
    tick();
    check("z8_halt",  {31'b0, halted}, 32'h1);
    check("z8_addr",  imem_addr, 32'h78);
    check("z8_valid", {31'b0, if_id_valid}, 32'h1);
    stall = 1'b1;
    tick();
    check("h_valid", {31'b0, if_id_valid}, 32'h0);
    check("h_addr",  imem_addr, 32'h78);
    check("h_halt",  {31'b0, halted}, 32'h1);

    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    check("hr_halt",  {31'b0, halted}, 32'h0);
    check("hr_addr",  imem_addr, 32'h0);
    check("hr_valid", {31'b0, if_id_valid}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check("hr2_instr", if_id_instr, 32'h518D_581B);
    check("hr2_pc4",   if_id_pc4, 32'h4);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check("wrap_addr",  imem_addr, 32'h0);
    check("wrap_pc4",   if_id_pc4, 32'h0);
    check("wrap_instr", if_id_instr, rom(32'hFFFF_FFFC));

    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_valid", {31'b0, if_id_valid}, 32'h0);
    check("arst_instr", if_id_instr, 32'h0);
    check("arst_pc4",   if_id_pc4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
